seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter DIV, default 1000, clk cycles per digit slot (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  one-cycle strobe; captures in_data and mode bits.
REQ-006 SHALL have port in_data  input  4*DIGITS  digit nibbles; nibble i = digit i, digit 0 rightmost.
REQ-007 SHALL have port hex_mode  input  1  1: nibbles 0-F shown as hex; 0: BCD.
REQ-008 SHALL have port blank_lz  input  1  1: suppress leading zeros.
REQ-009 SHALL have port seg  output  7  active-low segments, seg[6]=a ... seg[0]=g.
REQ-010 SHALL have port an  output  DIGITS  active-low one-hot digit enable.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan.
REQ-012 SHALL have port bad_digit  output  1  sticky flag: BCD nibble >9 displayed.

Function
REQ-013 SHALL keep a shadow register (data, hex_mode, blank_lz) and an active register; only the active register is displayed.
REQ-014 SHALL write the shadow register and set pending on load; a load while pending overwrites the shadow, last one wins.
REQ-015 SHALL run prescaler 0..DIV-1; tick = prescaler==DIV-1; prescaler wraps to 0 on tick.
REQ-016 SHALL advance digit index idx on tick, 0..DIGITS-1, wrapping DIGITS-1 -> 0.
REQ-017 SHALL, on a tick with idx==DIGITS-1, pulse frame_done for exactly that cycle and copy shadow to active if pending, clearing pending.
REQ-018 SHALL treat a load on that same tick cycle as arriving after the copy: the new value goes to shadow, pending stays 1, and the value shows from the next frame.
REQ-019 SHALL register seg and an; they reflect idx and active with one cycle of latency after any idx or active change.
REQ-020 SHALL drive an with bit idx low and all others high.
REQ-021 SHALL decode 0-9 as 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0000100.
REQ-022 SHALL, in hex mode, decode A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000.
REQ-023 SHALL, in BCD mode, show nibble >9 as blank (1111111) and set bad_digit in the same cycle seg updates.
REQ-024 SHALL, with blank_lz=1, blank digit i>0 when nibble i and all higher nibbles are 0; digit 0 is never blanked.
REQ-025 SHALL clear bad_digit on load; if load and a bad display coincide, the set wins.
REQ-026 SHALL keep scanning continuously, with no input stall; load is always accepted.

Reset
REQ-027 SHALL, while rst=1, asynchronously force prescaler=0, idx=0, shadow=0, active=0, pending=0, seg=1111111, an=all 1, frame_done=0, bad_digit=0.
REQ-028 SHALL, one cycle after rst deasserts, show digit 0 of active (seg=0000001, an=~1).
REQ-029 SHALL discard a pending load that is interrupted by a mid-frame reset.

Verification
REQ-030 Reset mid-scan -> all outputs take their reset values immediately, without waiting for a clk edge; after release, idx=0 and seg=0000001.
REQ-031 DIGITS=4, DIV=4, load in_data=16'h1234, BCD -> from the next frame, slots 0..3 show 4,3,2,1 with an=1110,1101,1011,0111; each slot lasts 4 cycles.
REQ-032 Load 16'h0070, blank_lz=1 -> digits 3 and 2 are blank (1111111), digit 1 shows 7, and digit 0 shows 0000001.
REQ-033 Load 16'h00A5, hex_mode=0, then hex_mode=1 -> BCD: digit 1 is blank and bad_digit=1; hex: digit 1=0001000 and bad_digit is cleared by the load.
REQ-034 Two loads (16'h1111, then 16'h2222) within one frame -> only 2222 is displayed next frame, and 1111 is never shown.
REQ-035 Load on the exact frame-wrap tick -> the current frame completes with old data, frame_done pulses once, and the new value appears one frame later.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered digit data, BCD/hex
// decode, optional leading-zero blanking and a sticky bad-BCD-digit flag.
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  bad_digit
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(DIV - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib, input logic hex);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = hex ? 7'b0001000 : SEG_BLANK;
      4'hB:    pat = hex ? 7'b1100000 : SEG_BLANK;
      4'hC:    pat = hex ? 7'b0110001 : SEG_BLANK;
      4'hD:    pat = hex ? 7'b1000010 : SEG_BLANK;
      4'hE:    pat = hex ? 7'b0110000 : SEG_BLANK;
      4'hF:    pat = hex ? 7'b0111000 : SEG_BLANK;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  logic [PW-1:0]         presc_r;
  logic [IW-1:0]         idx_r;
  logic [4*DIGITS-1:0]   shadow_data_r;
  logic                  shadow_hex_r;
  logic                  shadow_blz_r;
  logic                  pending_r;
  logic [4*DIGITS-1:0]   active_data_r;
  logic                  active_hex_r;
  logic                  active_blz_r;
  logic [6:0]            seg_r;
  logic [DIGITS-1:0]     an_r;
  logic                  frame_done_r;
  logic                  bad_digit_r;

  logic                  tick_s;
  logic                  frame_end_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_lz_s;
  logic                  zero_run_s;
  logic                  sel_s;
  logic [DIGITS-1:0]     an_next_s;
  logic [6:0]            seg_next_s;
  logic                  bad_set_s;

  assign tick_s      = (presc_r == PRESC_LAST);
  assign frame_end_s = tick_s && (idx_r == IDX_LAST);

  // Slot timing: prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
      idx_r   <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
      idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Double buffer; a load on the frame-end tick lands after the copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data_r <= '0;
      shadow_hex_r  <= 1'b0;
      shadow_blz_r  <= 1'b0;
      pending_r     <= 1'b0;
      active_data_r <= '0;
      active_hex_r  <= 1'b0;
      active_blz_r  <= 1'b0;
    end else begin
      if (frame_end_s && pending_r) begin
        active_data_r <= shadow_data_r;
        active_hex_r  <= shadow_hex_r;
        active_blz_r  <= shadow_blz_r;
      end
      if (load) begin
        shadow_data_r <= in_data;
        shadow_hex_r  <= hex_mode;
        shadow_blz_r  <= blank_lz;
        pending_r     <= 1'b1;
      end else if (frame_end_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Select current digit, leading-zero state and anode pattern.
  always_comb begin
    cur_nib_s  = 4'h0;
    cur_lz_s   = 1'b0;
    zero_run_s = 1'b1;
    sel_s      = 1'b0;
    an_next_s  = {DIGITS{1'b1}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_s   = zero_run_s && (active_data_r[4*i +: 4] == 4'h0);
      sel_s        = (idx_r == IW'(i));
      cur_nib_s    = cur_nib_s | (sel_s ? active_data_r[4*i +: 4] : 4'h0);
      cur_lz_s     = cur_lz_s | (sel_s && zero_run_s && (i != 0));
      an_next_s[i] = !sel_s;
    end
    if (active_blz_r && cur_lz_s) begin
      seg_next_s = SEG_BLANK;
    end else begin
      seg_next_s = seg7_decode(cur_nib_s, active_hex_r);
    end
    bad_set_s = !active_hex_r && (cur_nib_s > 4'd9);
  end

  // Registered outputs; frame_done is pre-decoded one cycle early so it lines up with the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r        <= SEG_BLANK;
      an_r         <= {DIGITS{1'b1}};
      frame_done_r <= 1'b0;
      bad_digit_r  <= 1'b0;
    end else begin
      seg_r        <= seg_next_s;
      an_r         <= an_next_s;
      frame_done_r <= (presc_r == PRESC_PRE) && (idx_r == IDX_LAST);
      if (bad_set_s) begin
        bad_digit_r <= 1'b1;
      end else if (load) begin
        bad_digit_r <= 1'b0;
      end
    end
  end

  assign seg        = seg_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;
  assign bad_digit  = bad_digit_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, DIV=4 (16-cycle frames).
module tb_seg7_scan_ctrl;

  localparam logic [6:0] S_0  = 7'b0000001;
  localparam logic [6:0] S_1  = 7'b1001111;
  localparam logic [6:0] S_2  = 7'b0010010;
  localparam logic [6:0] S_3  = 7'b0000110;
  localparam logic [6:0] S_4  = 7'b1001100;
  localparam logic [6:0] S_5  = 7'b0100100;
  localparam logic [6:0] S_6  = 7'b0100000;
  localparam logic [6:0] S_7  = 7'b0001111;
  localparam logic [6:0] S_8  = 7'b0000000;
  localparam logic [6:0] S_A  = 7'b0001000;
  localparam logic [6:0] S_BL = 7'b1111111;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] in_data;
  logic        hex_mode;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        bad_digit;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(.DIGITS(4), .DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .in_data    (in_data),
    .hex_mode   (hex_mode),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .bad_digit  (bad_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [15:0] d, input logic hx, input logic blz);
    in_data  = d;
    hex_mode = hx;
    blank_lz = blz;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Ends on the negedge where frame_done is high.
  task automatic wait_frame(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s wait_frame: frame_done not seen within 40 cycles", name);
    end
  endtask

  // Called on a frame_done negedge; checks the following frame and ends on its frame_done negedge.
  task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3, input string name);
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_fd;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      case (i / 4)
        0:       exp_seg = e0;
        1:       exp_seg = e1;
        2:       exp_seg = e2;
        default: exp_seg = e3;
      endcase
      exp_an = ~(4'b0001 << (i / 4));
      exp_fd = (i == 14);
      checks++;
      if (seg !== exp_seg) begin
        errors++;
        $display("FAIL %s seg cyc %0d: got %b want %b", name, i, seg, exp_seg);
      end
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL %s an cyc %0d: got %b want %b", name, i, an, exp_an);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL %s frame_done cyc %0d: got %b want %b", name, i, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_reset();
    #7;
    checks++;
    if (seg !== S_BL || an !== 4'b1111 || frame_done !== 1'b0 || bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got seg=%b an=%b fd=%b bad=%b want 1111111 1111 0 0",
               seg, an, frame_done, bad_digit);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (seg !== S_0 || an !== 4'b1110) begin
      errors++;
      $display("FAIL reset_release: got seg=%b an=%b want %b 1110", seg, an, S_0);
    end
  endtask

  task automatic test_bcd();
    wait_frame("bcd");
    @(negedge clk);
    do_load(16'h1234, 1'b0, 1'b0);
    wait_frame("bcd");
    check_frame(S_4, S_3, S_2, S_1, "bcd_1234");
  endtask

  task automatic test_blank_lz();
    wait_frame("lz");
    @(negedge clk);
    do_load(16'h0070, 1'b0, 1'b1);
    wait_frame("lz");
    check_frame(S_0, S_7, S_BL, S_BL, "blank_lz_0070");
  endtask

  task automatic test_bad_digit();
    wait_frame("bad");
    @(negedge clk);
    do_load(16'h00A5, 1'b0, 1'b0);
    wait_frame("bad");
    check_frame(S_5, S_BL, S_0, S_0, "bcd_00a5");
    checks++;
    if (bad_digit !== 1'b1) begin
      errors++;
      $display("FAIL bad_digit_set: got %b want 1", bad_digit);
    end
    // Move to slot 2 so the old BCD value cannot re-flag before the swap.
    repeat (9) @(negedge clk);
    do_load(16'h00A5, 1'b1, 1'b0);
    checks++;
    if (bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL bad_digit_clear: got %b want 0", bad_digit);
    end
    wait_frame("bad_hex");
    check_frame(S_5, S_A, S_0, S_0, "hex_00a5");
    checks++;
    if (bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL bad_digit_hex: got %b want 0", bad_digit);
    end
  endtask

  task automatic test_back_to_back();
    wait_frame("b2b");
    @(negedge clk);
    do_load(16'h1111, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    do_load(16'h2222, 1'b0, 1'b0);
    wait_frame("b2b");
    check_frame(S_2, S_2, S_2, S_2, "back_to_back");
  endtask

  task automatic test_frame_wrap();
    wait_frame("wrap");
    @(negedge clk);
    do_load(16'h3333, 1'b0, 1'b0);
    wait_frame("wrap");
    in_data  = 16'h5678;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    load     = 1'b1;
    check_frame(S_3, S_3, S_3, S_3, "wrap_old");
    check_frame(S_8, S_7, S_6, S_5, "wrap_new");
  endtask

  task automatic test_mid_reset();
    wait_frame("mid_rst");
    @(negedge clk);
    do_load(16'h00C0, 1'b0, 1'b0);
    wait_frame("mid_rst");
    @(negedge clk);
    do_load(16'h9999, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (bad_digit !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_pre_bad: got %b want 1", bad_digit);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg !== S_BL || an !== 4'b1111 || frame_done !== 1'b0 || bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_async: got seg=%b an=%b fd=%b bad=%b want 1111111 1111 0 0",
               seg, an, frame_done, bad_digit);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (seg !== S_0 || an !== 4'b1110) begin
      errors++;
      $display("FAIL mid_rst_release: got seg=%b an=%b want %b 1110", seg, an, S_0);
    end
    wait_frame("post_rst");
    check_frame(S_0, S_0, S_0, S_0, "pending_discarded");
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    in_data  = 16'h0000;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    test_reset();
    test_bcd();
    test_blank_lz();
    test_bad_digit();
    test_back_to_back();
    test_frame_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
